switch_mcu_opfetch: RTL and testbench
=====================================

SWITCH_MCU_OPFETCH -- requirements
Module: switch_mcu_opfetch

Interface
REQ-001 SHALL have ports: in_clk  in  1  sole clock; in_rst  in  1  asynchronous, active-low reset.
REQ-002 SHALL have decode-side ports:
- in_dec_valid  in  1  instruction offered
- out_dec_ready  out  1  instruction accepted this cycle
- in_rs1  in  5  source register 1 address
- in_rs1_en  in  1  source register 1 used
- in_rs2  in  5  source register 2 address
- in_rs2_en  in  1  source register 2 used
- in_imm  in  32  immediate
- in_imm_sel  in  1  operand B takes the immediate
- in_rd  in  5  destination address
- in_rd_en  in  1  destination written
- in_ctrl  in  16  opaque control word
REQ-003 SHALL have register-file ports:
- out_raddr_1, out_raddr_2  out  5  read addresses
- out_ren_1, out_ren_2  out  1  read enables
- in_rdata_1, in_rdata_2  in  32  read data, valid one cycle after the address
REQ-004 SHALL have writeback snoop ports, the same signals that drive the register-file write port: in_wb_wen  in  1; in_wb_waddr  in  5; in_wb_wdata  in  32.
REQ-005 SHALL have execute-side ports:
- out_ex_valid  out  1  operands valid
- in_ex_ready  in  1  execute accepts
- out_op_a, out_op_b  out  32  operands
- out_rd  out  5  destination address
- out_rd_en  out  1  destination written
- out_ctrl  out  16  control word

Function
REQ-006 SHALL implement a 3-state FSM: EMPTY, WAIT (read issued, register-file data present this cycle) and FULL (operands held in local registers).
REQ-007 Accept = in_dec_valid & out_dec_ready; out_dec_ready SHALL be 1 in EMPTY, and SHALL equal in_ex_ready in WAIT and in FULL.
REQ-008 On accept, SHALL combinationally drive out_raddr_n = in_rsN and out_ren_n = in_rsN_en & (in_rsN != 0); otherwise out_ren_n SHALL be 0 and out_raddr_n SHALL be 0.
REQ-009 On accept, SHALL register rd, rd_en, ctrl, imm, imm_sel, rsN and rsN_en.
REQ-010 On accept, if in_wb_wen and in_wb_waddr == in_rsN != 0, SHALL latch in_wb_wdata into a per-operand bypass register and set its bypass flag; otherwise SHALL clear the flag.
REQ-011 out_ex_valid SHALL be 1 in WAIT and in FULL, and 0 in EMPTY.
REQ-012 In WAIT, operand N SHALL be selected by this priority:
- 0 if rsN_en = 0 or rsN = 0;
- else in_wb_wdata if in_wb_wen and in_wb_waddr == rsN (current-cycle forward);
- else the bypass register if its flag is set;
- else in_rdata_n.
REQ-013 In FULL, operand N SHALL be in_wb_wdata on a current-cycle writeback match (same rules as REQ-012), else the hold register.
REQ-014 Each hold register SHALL update with in_wb_wdata on every cycle in FULL with a matching writeback.
REQ-015 out_op_b SHALL be the registered imm when imm_sel = 1, regardless of rs2.
REQ-016 Transitions from WAIT:
- in_ex_ready & accept -> WAIT;
- in_ex_ready & !in_dec_valid -> EMPTY;
- !in_ex_ready -> FULL, capturing the REQ-012 operand values into the hold registers.
REQ-017 Transitions from FULL: the same as from WAIT when in_ex_ready = 1; otherwise stay in FULL.
REQ-018 Transitions from EMPTY: accept -> WAIT; otherwise stay in EMPTY.
REQ-019 Latency SHALL be: accept in cycle t, out_ex_valid in cycle t+1. Sustained throughput SHALL be 1 instruction per cycle when in_ex_ready = 1.
REQ-020 out_rd, out_rd_en and out_ctrl SHALL be stable while out_ex_valid = 1 and in_ex_ready = 0.
REQ-021 Register address 0 SHALL always read as 0 and SHALL never be forwarded.

Reset
REQ-022 When in_rst = 0, SHALL enter EMPTY immediately and clear all registers, bypass flags and hold registers to 0.
REQ-023 During reset, out_ex_valid = 0, out_dec_ready = 0, out_ren_n = 0, and all data outputs SHALL be 0.
REQ-024 A reset in WAIT or FULL SHALL drop the in-flight instruction with no partial output.
REQ-025 out_dec_ready SHALL be 1 in the first cycle after reset deassertion.

Structure
REQ-026 A shared package (switch_mcu_pkg) SHALL hold the FSM state encoding, REG_ADDR_W = 5, XLEN = 32 and CTRL_W = 16.
REQ-027 A single sub-module, switch_mcu_opfetch_fwd (the per-operand forward mux plus hold register), SHALL be instantiated twice.

Verification
REQ-028 x1 = 5 in the register file; accept rs1 = 1 with in_ex_ready = 1 -> cycle t+1: out_ex_valid = 1, out_op_a = 5.
REQ-029 Accept rs1 = 2 in the same cycle as a writeback x2 = 0xA5 -> out_op_a = 0xA5, not the old value.
REQ-030 Accept rs2 = 3, hold in_ex_ready = 0 for 3 cycles, writeback x3 = 0x77 in the second of them -> out_op_b = 0x77 on release, and the FSM passes WAIT -> FULL -> EMPTY.
REQ-031 Back-to-back accepts rs1 = 4, then rs1 = 5 with in_ex_ready = 1 -> out_ex_valid = 1 for 2 consecutive cycles, operands in order.
REQ-032 rs1 = 0 with a writeback x0 = 0xFF pending -> out_op_a = 0 and out_ren_1 = 0.
REQ-033 Assert in_rst = 0 while in FULL -> out_ex_valid = 0 within the same cycle; one cycle after release, out_dec_ready = 1.

Source files
------------

// File: rtl/switch_mcu_pkg.sv
// Shared types and widths for the switch MCU operand-fetch stage.
// Holds the fetch FSM encoding and the latched instruction bundle.
package switch_mcu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int CTRL_W     = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FULL  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  rd_en;
    logic [CTRL_W-1:0]     ctrl;
    logic [XLEN-1:0]       imm;
    logic                  imm_sel;
  } id_ex_t;

  // x0 is hardwired, so it never matches a writeback
  function automatic logic wb_hit(
    input logic                  wen,
    input logic [REG_ADDR_W-1:0] waddr,
    input logic [REG_ADDR_W-1:0] rs
  );
    return wen && (waddr == rs) && (rs != '0);
  endfunction

endpackage

// File: rtl/switch_mcu_opfetch_if.sv
// Decode, register-file, writeback and execute signals of the
// operand-fetch stage; slave is the stage, master its environment.
interface switch_mcu_opfetch_if;
  import switch_mcu_pkg::*;

  logic                  in_dec_valid;
  logic                  out_dec_ready;
  logic [REG_ADDR_W-1:0] in_rs1;
  logic                  in_rs1_en;
  logic [REG_ADDR_W-1:0] in_rs2;
  logic                  in_rs2_en;
  logic [XLEN-1:0]       in_imm;
  logic                  in_imm_sel;
  logic [REG_ADDR_W-1:0] in_rd;
  logic                  in_rd_en;
  logic [CTRL_W-1:0]     in_ctrl;

  logic [REG_ADDR_W-1:0] out_raddr_1;
  logic [REG_ADDR_W-1:0] out_raddr_2;
  logic                  out_ren_1;
  logic                  out_ren_2;
  logic [XLEN-1:0]       in_rdata_1;
  logic [XLEN-1:0]       in_rdata_2;

  logic                  in_wb_wen;
  logic [REG_ADDR_W-1:0] in_wb_waddr;
  logic [XLEN-1:0]       in_wb_wdata;

  logic                  out_ex_valid;
  logic                  in_ex_ready;
  logic [XLEN-1:0]       out_op_a;
  logic [XLEN-1:0]       out_op_b;
  logic [REG_ADDR_W-1:0] out_rd;
  logic                  out_rd_en;
  logic [CTRL_W-1:0]     out_ctrl;

  modport slave (
    input  in_dec_valid, in_rs1, in_rs1_en,
    input  in_rs2, in_rs2_en, in_imm, in_imm_sel,
    input  in_rd, in_rd_en, in_ctrl,
    input  in_rdata_1, in_rdata_2,
    input  in_wb_wen, in_wb_waddr, in_wb_wdata,
    input  in_ex_ready,
    output out_dec_ready, out_raddr_1, out_raddr_2,
    output out_ren_1, out_ren_2, out_ex_valid,
    output out_op_a, out_op_b, out_rd, out_rd_en,
    output out_ctrl
  );

  modport master (
    output in_dec_valid, in_rs1, in_rs1_en,
    output in_rs2, in_rs2_en, in_imm, in_imm_sel,
    output in_rd, in_rd_en, in_ctrl,
    output in_rdata_1, in_rdata_2,
    output in_wb_wen, in_wb_waddr, in_wb_wdata,
    output in_ex_ready,
    input  out_dec_ready, out_raddr_1, out_raddr_2,
    input  out_ren_1, out_ren_2, out_ex_valid,
    input  out_op_a, out_op_b, out_rd, out_rd_en,
    input  out_ctrl
  );

endinterface

// File: rtl/switch_mcu_opfetch_fwd.sv
// One operand lane: source tracking, accept-time bypass,
// stall hold register and writeback forward mux.
module switch_mcu_opfetch_fwd
  import switch_mcu_pkg::*;
(
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  accept,
  input  logic                  ex_ready,
  input  fetch_state_t          state,
  input  logic [REG_ADDR_W-1:0] dec_rs,
  input  logic                  dec_rs_en,
  input  logic                  wb_wen,
  input  logic [REG_ADDR_W-1:0] wb_waddr,
  input  logic [XLEN-1:0]       wb_wdata,
  input  logic [XLEN-1:0]       rdata,
  output logic [XLEN-1:0]       operand
);

  logic [REG_ADDR_W-1:0] rs_q;
  logic                  rs_en_q;
  logic [XLEN-1:0]       byp_q;
  logic                  byp_v;
  logic [XLEN-1:0]       hold_q;

  logic            live;
  logic            cur_hit;
  logic            acc_hit;
  logic [XLEN-1:0] wait_val;
  logic [XLEN-1:0] full_val;

  always_comb begin
    live     = rs_en_q && (rs_q != '0);
    cur_hit  = live && wb_hit(wb_wen, wb_waddr, rs_q);
    acc_hit  = wb_hit(wb_wen, wb_waddr, dec_rs);
    wait_val = '0;
    full_val = '0;
    if (cur_hit) begin
      wait_val = wb_wdata;
      full_val = wb_wdata;
    end else if (live) begin
      wait_val = byp_v ? byp_q : rdata;
      full_val = hold_q;
    end
    operand = '0;
    unique case (state)
      ST_WAIT: operand = wait_val;
      ST_FULL: operand = full_val;
      default: operand = '0;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      rs_q    <= '0;
      rs_en_q <= 1'b0;
      byp_q   <= '0;
      byp_v   <= 1'b0;
      hold_q  <= '0;
    end else begin
      if (accept) begin
        rs_q    <= dec_rs;
        rs_en_q <= dec_rs_en;
        byp_v   <= acc_hit;
        byp_q   <= acc_hit ? wb_wdata : '0;
      end
      // hold tracks the architectural value while stalled
      if (state == ST_WAIT && !ex_ready)
        hold_q <= wait_val;
      else if (state == ST_FULL && cur_hit)
        hold_q <= wb_wdata;
    end
  end

endmodule

// File: rtl/switch_mcu_opfetch.sv
// Operand-fetch stage: reads the register file one cycle after
// accept and forwards writebacks until execute takes the operands.
module switch_mcu_opfetch
  import switch_mcu_pkg::*;
(
  input  logic                 in_clk,
  input  logic                 in_rst,
  switch_mcu_opfetch_if.slave  bus
);

  fetch_state_t    state_q;
  fetch_state_t    state_d;
  id_ex_t          ins_q;
  logic            dec_ready;
  logic            accept;
  logic            ex_valid;
  logic [XLEN-1:0] opnd_1;
  logic [XLEN-1:0] opnd_2;

  always_comb begin
    ex_valid  = (state_q == ST_WAIT) || (state_q == ST_FULL);
    dec_ready = in_rst &&
                ((state_q == ST_EMPTY) || bus.in_ex_ready);
    accept    = bus.in_dec_valid && dec_ready;
    state_d   = state_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) state_d = ST_WAIT;
      end
      ST_WAIT, ST_FULL: begin
        if (!bus.in_ex_ready) state_d = ST_FULL;
        else if (accept)      state_d = ST_WAIT;
        else                  state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q <= ST_EMPTY;
      ins_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept)
        ins_q <= '{rd:      bus.in_rd,
                   rd_en:   bus.in_rd_en,
                   ctrl:    bus.in_ctrl,
                   imm:     bus.in_imm,
                   imm_sel: bus.in_imm_sel};
    end
  end

  switch_mcu_opfetch_fwd u_fwd_1 (
    .in_clk    (in_clk),
    .in_rst    (in_rst),
    .accept    (accept),
    .ex_ready  (bus.in_ex_ready),
    .state     (state_q),
    .dec_rs    (bus.in_rs1),
    .dec_rs_en (bus.in_rs1_en),
    .wb_wen    (bus.in_wb_wen),
    .wb_waddr  (bus.in_wb_waddr),
    .wb_wdata  (bus.in_wb_wdata),
    .rdata     (bus.in_rdata_1),
    .operand   (opnd_1)
  );

  switch_mcu_opfetch_fwd u_fwd_2 (
    .in_clk    (in_clk),
    .in_rst    (in_rst),
    .accept    (accept),
    .ex_ready  (bus.in_ex_ready),
    .state     (state_q),
    .dec_rs    (bus.in_rs2),
    .dec_rs_en (bus.in_rs2_en),
    .wb_wen    (bus.in_wb_wen),
    .wb_waddr  (bus.in_wb_waddr),
    .wb_wdata  (bus.in_wb_wdata),
    .rdata     (bus.in_rdata_2),
    .operand   (opnd_2)
  );

  assign bus.out_dec_ready = dec_ready;
  assign bus.out_raddr_1   = accept ? bus.in_rs1 : '0;
  assign bus.out_raddr_2   = accept ? bus.in_rs2 : '0;
  assign bus.out_ren_1     = accept && bus.in_rs1_en &&
                             (bus.in_rs1 != '0);
  assign bus.out_ren_2     = accept && bus.in_rs2_en &&
                             (bus.in_rs2 != '0);
  assign bus.out_ex_valid  = ex_valid;
  assign bus.out_op_a      = opnd_1;
  assign bus.out_op_b      = (ex_valid && ins_q.imm_sel)
                             ? ins_q.imm : opnd_2;
  assign bus.out_rd        = ins_q.rd;
  assign bus.out_rd_en     = ins_q.rd_en;
  assign bus.out_ctrl      = ins_q.ctrl;

endmodule

// File: tb/tb_switch_mcu_opfetch.sv
// Bench for switch_mcu_opfetch: directed scenarios then random
// traffic, checked against a transaction-level operand model.
module tb_switch_mcu_opfetch;

  logic in_clk = 1'b0;
  logic in_rst = 1'b1;
  always #5 in_clk = ~in_clk;

  switch_mcu_opfetch_if bus ();

  switch_mcu_opfetch dut (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .bus    (bus)
  );

  logic [31:0] rf [32];

  always @(posedge in_clk) begin
    if (!in_rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
      bus.in_rdata_1 <= $urandom();
      bus.in_rdata_2 <= $urandom();
    end else begin
      bus.in_rdata_1 <= bus.out_ren_1 ? rf[bus.out_raddr_1] : $urandom();
      bus.in_rdata_2 <= bus.out_ren_2 ? rf[bus.out_raddr_2] : $urandom();
      if (bus.in_wb_wen && bus.in_wb_waddr != 5'd0)
        rf[bus.in_wb_waddr] <= bus.in_wb_wdata;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  // one in-flight instruction as seen by execute
  bit          m_busy;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic        m_en1, m_en2, m_sel, m_rd_en;
  logic [31:0] m_imm;
  logic [15:0] m_ctrl;
  bit          s_acc;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // architectural value of rs now, including this cycle's writeback
  function automatic logic [31:0] opv(input logic [4:0] rs,
                                      input logic en);
    if (!en || rs == 5'd0) return 32'd0;
    if (bus.in_wb_wen && bus.in_wb_waddr == rs) return bus.in_wb_wdata;
    return rf[rs];
  endfunction

  task automatic sample();
    bit exp_ready;
    @(negedge in_clk);
    exp_ready = !m_busy || bus.in_ex_ready;
    s_acc = bus.in_dec_valid && exp_ready;
    chk("dec_ready", 32'(bus.out_dec_ready), 32'(exp_ready));
    chk("ex_valid", 32'(bus.out_ex_valid), 32'(m_busy));
    chk("raddr_1", 32'(bus.out_raddr_1), s_acc ? 32'(bus.in_rs1) : 0);
    chk("raddr_2", 32'(bus.out_raddr_2), s_acc ? 32'(bus.in_rs2) : 0);
    chk("ren_1", 32'(bus.out_ren_1),
        32'(s_acc && bus.in_rs1_en && bus.in_rs1 != 0));
    chk("ren_2", 32'(bus.out_ren_2),
        32'(s_acc && bus.in_rs2_en && bus.in_rs2 != 0));
    if (m_busy) begin
      chk("op_a", bus.out_op_a, opv(m_rs1, m_en1));
      chk("op_b", bus.out_op_b, m_sel ? m_imm : opv(m_rs2, m_en2));
      chk("rd", 32'(bus.out_rd), 32'(m_rd));
      chk("rd_en", 32'(bus.out_rd_en), 32'(m_rd_en));
      chk("ctrl", 32'(bus.out_ctrl), 32'(m_ctrl));
    end
  endtask

  task automatic advance();
    if (s_acc) begin
      m_busy  = 1'b1;
      m_rs1   = bus.in_rs1;
      m_en1   = bus.in_rs1_en;
      m_rs2   = bus.in_rs2;
      m_en2   = bus.in_rs2_en;
      m_sel   = bus.in_imm_sel;
      m_imm   = bus.in_imm;
      m_rd    = bus.in_rd;
      m_rd_en = bus.in_rd_en;
      m_ctrl  = bus.in_ctrl;
    end else if (m_busy && bus.in_ex_ready) begin
      m_busy = 1'b0;
    end
    @(posedge in_clk);
    #1;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic set_dec(input logic v, input logic [4:0] r1,
                         input logic e1, input logic [4:0] r2,
                         input logic e2, input logic sel);
    bus.in_dec_valid = v;
    bus.in_rs1       = r1;
    bus.in_rs1_en    = e1;
    bus.in_rs2       = r2;
    bus.in_rs2_en    = e2;
    bus.in_imm_sel   = sel;
    bus.in_imm       = $urandom();
    bus.in_rd        = 5'($urandom_range(0, 31));
    bus.in_rd_en     = 1'($urandom_range(0, 1));
    bus.in_ctrl      = 16'($urandom_range(0, 65535));
  endtask

  task automatic set_wb(input logic wen, input logic [4:0] a,
                        input logic [31:0] d);
    bus.in_wb_wen   = wen;
    bus.in_wb_waddr = a;
    bus.in_wb_wdata = d;
  endtask

  initial begin
    m_busy = 1'b0;
    s_acc  = 1'b0;
    bus.in_ex_ready = 1'b1;
    set_dec(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0);
    set_wb(1'b0, 5'd0, 32'd0);
    #1 in_rst = 1'b0;
    #6;
    chk("rst_dec_ready", 32'(bus.out_dec_ready), 0);
    chk("rst_ex_valid", 32'(bus.out_ex_valid), 0);
    chk("rst_ren_1", 32'(bus.out_ren_1), 0);
    chk("rst_raddr_1", 32'(bus.out_raddr_1), 0);
    chk("rst_op_a", bus.out_op_a, 0);
    chk("rst_op_b", bus.out_op_b, 0);
    chk("rst_rd", 32'(bus.out_rd), 0);
    chk("rst_ctrl", 32'(bus.out_ctrl), 0);
    @(posedge in_clk);
    @(posedge in_clk);
    #1 in_rst = 1'b1;
    set_dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    sample();
    chk("post_rst_ready", 32'(bus.out_dec_ready), 1);
    advance();

    for (int i = 1; i < 32; i++) begin
      set_wb(1'b1, 5'(i), i == 1 ? 32'd5 :
             i == 2 ? 32'h22 : 32'h100 * i);
      cyc();
    end
    set_wb(1'b0, 5'd0, 32'd0);

    // x1 read, one-cycle latency
    set_dec(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0);
    sample();
    chk("r28_ren_1", 32'(bus.out_ren_1), 1);
    chk("r28_raddr_1", 32'(bus.out_raddr_1), 1);
    advance();
    set_dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    sample();
    chk("r28_valid", 32'(bus.out_ex_valid), 1);
    chk("r28_op_a", bus.out_op_a, 32'd5);
    advance();

    // writeback in the accept cycle
    set_dec(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0);
    set_wb(1'b1, 5'd2, 32'hA5);
    cyc();
    set_dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    set_wb(1'b0, 5'd0, 32'd0);
    sample();
    chk("r29_op_a", bus.out_op_a, 32'hA5);
    advance();

    // stall with writeback during the stall
    set_dec(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    cyc();
    set_dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    bus.in_ex_ready = 1'b0;
    sample();
    chk("r30_wait_valid", 32'(bus.out_ex_valid), 1);
    advance();
    set_wb(1'b1, 5'd3, 32'h77);
    sample();
    chk("r30_fwd_b", bus.out_op_b, 32'h77);
    advance();
    set_wb(1'b0, 5'd0, 32'd0);
    sample();
    chk("r30_hold_b", bus.out_op_b, 32'h77);
    chk("r30_full_ready", 32'(bus.out_dec_ready), 0);
    advance();
    bus.in_ex_ready = 1'b1;
    sample();
    chk("r30_release_b", bus.out_op_b, 32'h77);
    advance();
    sample();
    chk("r30_empty", 32'(bus.out_ex_valid), 0);
    advance();

    // back-to-back
    set_dec(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0);
    cyc();
    set_dec(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
    sample();
    chk("r31_valid_1", 32'(bus.out_ex_valid), 1);
    chk("r31_op_a_1", bus.out_op_a, 32'h400);
    advance();
    set_dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    sample();
    chk("r31_valid_2", 32'(bus.out_ex_valid), 1);
    chk("r31_op_a_2", bus.out_op_a, 32'h500);
    advance();
    cyc();

    // x0 never read or forwarded
    set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    set_wb(1'b1, 5'd0, 32'hFF);
    sample();
    chk("r32_ren_1", 32'(bus.out_ren_1), 0);
    advance();
    set_dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    sample();
    chk("r32_op_a", bus.out_op_a, 32'd0);
    advance();
    set_wb(1'b0, 5'd0, 32'd0);

    // reset while stalled
    set_dec(1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0);
    cyc();
    set_dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    bus.in_ex_ready = 1'b0;
    cyc();
    #2 in_rst = 1'b0;
    #1;
    chk("r33_valid", 32'(bus.out_ex_valid), 0);
    chk("r33_ready", 32'(bus.out_dec_ready), 0);
    chk("r33_op_a", bus.out_op_a, 32'd0);
    chk("r33_rd", 32'(bus.out_rd), 0);
    m_busy = 1'b0;
    @(posedge in_clk);
    #1 in_rst = 1'b1;
    sample();
    chk("r33_post_ready", 32'(bus.out_dec_ready), 1);
    advance();

    for (int i = 1; i < 32; i++) begin
      set_wb(1'b1, 5'(i), $urandom());
      cyc();
    end

    for (int n = 0; n < 400; n++) begin
      set_dec(1'($urandom_range(0, 3) != 0),
              5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
              5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)));
      bus.in_ex_ready = 1'($urandom_range(0, 2) != 0);
      set_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
             $urandom());
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
